booth_multiplier_param: RTL
===========================

Name: booth_multiplier_param

Overview:
- Parametrised, iterative radix-2 Booth multiplier; the next generation of the team's 16-bit serial-load Booth multiplier.
- Loads operands serially on one shared data bus: multiplicand, then multiplier.
- Supports a selectable signed/unsigned mode and a handshake: in_valid for operand load, busy/done for status.
- Sits behind a bus/datapath controller that streams operands over one WIDTH-bit port and collects a 2*WIDTH-bit product.

Parameters:
- WIDTH, 16: operand width in bits, legal range 4..32.
- CNT_W, $clog2(WIDTH+2): iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a new multiplication; honoured only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the accepted start.
- in_valid  input  1  data_in holds an operand this cycle.
- data_in  input  WIDTH  operand bus: multiplicand first, then multiplier.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when output_data is updated.
- output_data  output  2*WIDTH  product; holds its value until the next done.

Behaviour:
- Reset: on rst high at a clock edge, state goes to IDLE. busy=0, done=0, output_data=0. All internal registers clear. Applies in any state, including mid-CALC; any partial result is discarded.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE:
  - start=1 moves to LOAD_A and latches signed_mode into mode_r.
  - in_valid is ignored, including when it coincides with start.
- LOAD_A:
  - If in_valid=1, capture M = data_in, extended to WIDTH+1 bits (sign-extend if mode_r=1, zero-extend if mode_r=0). Move to LOAD_B.
  - Otherwise wait indefinitely.
- LOAD_B:
  - If in_valid=1, capture Q = data_in, extended to WIDTH+1 bits the same way. Also set A = 0 (WIDTH+1 bits), Q_1 = 0, and cnt = WIDTH if mode_r=1, else WIDTH+1. Move to CALC.
  - Otherwise wait.
- CALC, one Booth step per cycle:
  - Inspect {Q[0],Q_1}. For 01, A = A+M; for 10, A = A-M; for 00/11, A is unchanged. Arithmetic is (WIDTH+1)-bit and wraps.
  - Then arithmetic-shift {A,Q,Q_1} right by one, with A's MSB replicated.
  - Decrement cnt.
  - On the step where cnt goes from 1 to 0, at the same edge: output_data = low 2*WIDTH bits of the shifted {A,Q} (dropping the extension), done = 1, and state moves to DONE.
- DONE: done is high for exactly this one cycle. Next edge goes to IDLE with done = 0. start is ignored in DONE.
- Extended width: the WIDTH+1-bit extension is mandatory, so that M = -2^(WIDTH-1) and full-scale unsigned operands produce exact products.
- Latency, measured from the edge capturing the multiplier:
  - Signed mode: done is high after WIDTH edges.
  - Unsigned mode: done is high after WIDTH+1 edges.
  - busy drops one edge after done.
- Ignored inputs:
  - start while busy=1 has no effect and is not queued.
  - Changes to signed_mode after start is accepted have no effect.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE.
- output_data is stable between done pulses, including while a new operation is in progress.

Test Plan:
- Basic signed (WIDTH=16): start with signed_mode=1, then in_valid with data_in=-10, then in_valid with data_in=11. Required: output_data=32'hFFFF_FF92 (-110), done pulses exactly 16 cycles after the multiplier is captured, busy=0 on the next cycle.
- Most-negative operands (WIDTH=16, signed): -32768 * -32768 -> 32'h4000_0000. Also -32768 * 1 -> 32'hFFFF_8000.
- Unsigned: signed_mode=0, 16'hFFFF * 16'hFFFF -> 32'hFFFE_0001. done pulses 17 cycles after capture.
- Handshake stalls: hold in_valid low for 3 cycles in each of LOAD_A and LOAD_B. Pulse start during CALC, and flip signed_mode during CALC. Required: a single correct result (7 * -3 -> 32'hFFFF_FFEB), with no extra done pulse.
- Reset mid-operation: assert rst for one cycle in the 5th CALC cycle. Required: busy=0, done=0, output_data=0 on the next cycle. A fresh 3 * 4 then yields 32'h0000_000C.
- WIDTH=8 instance: signed -128 * 127 -> 16'hC080. Unsigned 8'hFF * 8'h02 -> 16'h01FE.

Source files
------------

// File: rtl/booth_multiplier_param.sv
// Parametrised iterative radix-2 Booth multiplier with a serial operand load.
//
// Both operands arrive over one shared WIDTH-bit bus, the multiplicand first
// and then the multiplier. Each operand is qualified by in_valid. One Booth
// step runs per clock. Operands are extended to WIDTH+1 bits, so the
// most-negative signed value and full-scale unsigned values multiply exactly.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request a new multiplication (accepted only in IDLE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled on start)
//   in_valid     data_in carries an operand this cycle
//   data_in      operand bus: multiplicand, then multiplier
//   busy         high in every state except IDLE
//   done         one-cycle pulse when output_data is updated
//   output_data  2*WIDTH-bit product, held until the next done
module booth_multiplier_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   output_data
);

    localparam int XW = WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0]      a_r;
    logic [XW-1:0]      q_r;
    logic [XW-1:0]      m_r;
    logic               q1_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mode_r;
    logic [2*WIDTH-1:0] out_r;

    logic [XW-1:0]      ext_in;
    logic [XW-1:0]      a_sum;
    logic [2*XW:0]      step;   // {A,Q,Q_1} after add/sub and the arithmetic shift

    always_comb begin
        ext_in = mode_r ? {data_in[WIDTH-1], data_in} : {1'b0, data_in};
    end

    always_comb begin
        a_sum = a_r;
        case ({q_r[0], q1_r})
            2'b01:   a_sum = a_r + m_r;
            2'b10:   a_sum = a_r - m_r;
            default: a_sum = a_r;
        endcase
        step = {a_sum[XW-1], a_sum, q_r};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = LOAD_A;
            LOAD_A:  if (in_valid) state_nxt = LOAD_B;
            LOAD_B:  if (in_valid) state_nxt = CALC;
            CALC:    if (cnt_r == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        output_data = out_r;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
            q1_r   <= 1'b0;
            cnt_r  <= '0;
            mode_r <= 1'b0;
            out_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= signed_mode;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        m_r <= ext_in;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        q_r   <= ext_in;
                        a_r   <= '0;
                        q1_r  <= 1'b0;
                        cnt_r <= mode_r ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
                    end
                end
                CALC: begin
                    a_r   <= step[2*XW:XW+1];
                    q_r   <= step[XW:1];
                    q1_r  <= step[0];
                    cnt_r <= cnt_r - CNT_W'(1);
                    // In signed mode only WIDTH steps run, so the product is
                    // {A, Q[WIDTH:1]}. Q[0] still holds the multiplier's
                    // extension bit. In unsigned mode all WIDTH+1 steps run,
                    // so the product fills {A,Q}.
                    if (cnt_r == CNT_W'(1)) begin
                        out_r <= mode_r ? step[2*WIDTH+1:2] : step[2*WIDTH:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
